// File: rtl/simd_pkg.sv
// Shared definitions for the warp issue sequencer: opcodes, issue FSM encoding
// and the slice-mask extraction helper.
package simd_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } issue_state_t;

    // Upper bound on WARP supported by slice_bits.
    localparam int MAX_THREADS = 1024;

    function automatic int pass_width(input int passes);
        return (passes > 1) ? $clog2(passes) : 1;
    endfunction

    // Thread-mask bits of pass 'pass', right-aligned; callers truncate to LANES.
    function automatic logic [MAX_THREADS-1:0] slice_bits(
        input logic [MAX_THREADS-1:0] mask,
        input int                     lanes,
        input int                     pass
    );
        logic [MAX_THREADS-1:0] keep;
        keep = {MAX_THREADS{1'b1}};
        keep = ~(keep << lanes);
        return (mask >> (pass * lanes)) & keep;
    endfunction

endpackage

// File: rtl/simd_result_collector.sv
// Captures registered lane results one cycle after each issued pass and
// assembles them into the warp-wide result word.
module simd_result_collector
    import simd_pkg::*;
#(
    parameter int W     = 32,
    parameter int LANES = 8,
    parameter int WARP  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        issue_valid,
    input  logic [pass_width(WARP/LANES)-1:0] issue_pass,
    input  logic [LANES-1:0]            issue_mask,
    input  logic [LANES*W-1:0]          lane_out,
    output logic [WARP*W-1:0]           res_data
);

    localparam int PASSES  = WARP / LANES;
    localparam int PW      = pass_width(PASSES);
    localparam int SLICE_W = LANES * W;

    logic              cap_valid_reg;
    logic [PW-1:0]     cap_pass_reg;
    logic [LANES-1:0]  cap_mask_reg;
    logic [WARP*W-1:0] res_data_reg;
    logic [SLICE_W-1:0] gated;

    // Inactive lanes hold whatever they computed last; force them to zero.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_gate
            assign gated[gi*W +: W] = cap_mask_reg[gi] ? lane_out[gi*W +: W] : '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_valid_reg <= 1'b0;
            cap_pass_reg  <= '0;
            cap_mask_reg  <= '0;
            res_data_reg  <= '0;
        end else begin
            cap_valid_reg <= issue_valid;
            cap_pass_reg  <= issue_pass;
            cap_mask_reg  <= issue_mask;
            if (clear) begin
                res_data_reg <= '0;
            end else if (cap_valid_reg) begin
                res_data_reg[int'(cap_pass_reg)*SLICE_W +: SLICE_W] <= gated;
            end
        end
    end

    assign res_data = res_data_reg;

endmodule

// File: rtl/simd_warp_issue.sv
// Issues one warp-wide ALU instruction onto LANES physical lanes, one slice per
// cycle, skipping all-inactive slices, and returns the assembled warp result.
module simd_warp_issue
    import simd_pkg::*;
#(
    parameter int W     = 32,
    parameter int LANES = 8,
    parameter int WARP  = 32,
    parameter int TAG_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_opcode,
    input  logic [WARP-1:0]    in_mask,
    input  logic [WARP*W-1:0]  in_a,
    input  logic [WARP*W-1:0]  in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic [LANES-1:0]   lane_active,
    output logic [1:0]         lane_opcode,
    output logic [LANES*W-1:0] lane_a,
    output logic [LANES*W-1:0] lane_b,
    input  logic [LANES*W-1:0] lane_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WARP*W-1:0]  res_data,
    output logic [WARP-1:0]    res_mask,
    output logic [TAG_W-1:0]   res_tag
);

    localparam int PASSES  = WARP / LANES;
    localparam int PW      = pass_width(PASSES);
    localparam int SLICE_W = LANES * W;

    issue_state_t      state_reg, state_next;
    logic [PW-1:0]     pass_reg, pass_next;
    logic [1:0]        op_reg;
    logic [WARP-1:0]   mask_reg;
    logic [WARP*W-1:0] a_reg, b_reg;
    logic [TAG_W-1:0]  tag_reg;

    logic [LANES-1:0]  slice_mask [PASSES];
    logic [PASSES-1:0] slice_nz;
    logic [PW-1:0]     cur_pass;
    logic              found, more, issue, accept;

    genvar gi;
    generate
        for (gi = 0; gi < PASSES; gi++) begin : g_slice
            assign slice_mask[gi] = LANES'(slice_bits(MAX_THREADS'(mask_reg), LANES, gi));
            assign slice_nz[gi]   = |slice_mask[gi];
        end
    endgenerate

    // Lowest pending non-empty pass, and whether another one follows it.
    always_comb begin
        cur_pass = '0;
        found    = 1'b0;
        more     = 1'b0;
        for (int p = 0; p < PASSES; p++) begin
            if (slice_nz[p] && (p >= int'(pass_reg))) begin
                if (found) begin
                    more = 1'b1;
                end else begin
                    found    = 1'b1;
                    cur_pass = PW'(p);
                end
            end
        end
    end

    assign issue = (state_reg == ST_ISSUE) && found;

    always_comb begin
        state_next = state_reg;
        pass_next  = pass_reg;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    pass_next  = '0;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!found) begin
                    state_next = ST_DONE;
                end else begin
                    pass_next = PW'(int'(cur_pass) + 1);
                    if (!more) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: state_next = ST_DONE;
            ST_DONE: begin
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pass_reg  <= '0;
            op_reg    <= OP_NOP;
            mask_reg  <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            tag_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pass_reg  <= pass_next;
            if (accept) begin
                op_reg   <= in_opcode;
                mask_reg <= in_mask;
                a_reg    <= in_a;
                b_reg    <= in_b;
                tag_reg  <= in_tag;
            end
        end
    end

    always_comb begin
        lane_active = '0;
        lane_opcode = OP_NOP;
        lane_a      = '0;
        lane_b      = '0;
        if (issue) begin
            lane_active = slice_mask[cur_pass];
            lane_opcode = op_reg;
            lane_a      = a_reg[int'(cur_pass)*SLICE_W +: SLICE_W];
            lane_b      = b_reg[int'(cur_pass)*SLICE_W +: SLICE_W];
        end
    end

    simd_result_collector #(
        .W     (W),
        .LANES (LANES),
        .WARP  (WARP)
    ) u_collector (
        .clk         (clk),
        .rst         (rst),
        .clear       (accept),
        .issue_valid (issue),
        .issue_pass  (cur_pass),
        .issue_mask  (lane_active),
        .lane_out    (lane_out),
        .res_data    (res_data)
    );

    assign in_ready  = (state_reg == ST_IDLE);
    assign res_valid = (state_reg == ST_DONE);
    assign res_mask  = mask_reg;
    assign res_tag   = tag_reg;

endmodule
